// File: rtl/imem_load_ctrl_pkg.sv
// rtl/imem_load_ctrl_pkg.sv - shared types and constants for the instruction memory loader
package imem_load_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int DEFAULT_DEPTH  = 64;
  localparam int DEFAULT_N_BITS = 32;

  // addi x0, x0, 0; kept for a future option that feeds NOPs while the core is held
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - boot loader and read-port arbiter for the core's instruction RAM
// Streams a program into RAM, zero-fills the remainder, then releases the core and serves fetches.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int N_Bits = DEFAULT_N_BITS,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [N_Bits-1:0] in_data,
  output logic              in_ready,
  input  logic [N_Bits-1:0] core_pc,
  output logic [N_Bits-1:0] core_instr,
  output logic              core_rst_n,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N_Bits-1:0] mem_wdata,
  input  logic [N_Bits-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_W  = DEPTH_W - 1'b1;

  state_t          state;
  state_t          next_state;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] wr_ptr_inc;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] cnt_start;
  logic            accept_start;

  // Only the word index of the byte PC is used; fetches wrap modulo DEPTH.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{core_pc[1:0], core_pc[N_Bits-1:ADDR_W+2]};

  assign wr_ptr_inc   = wr_ptr + 1'b1;
  assign cnt_start    = (word_count > DEPTH_W) ? DEPTH_W : word_count;
  assign accept_start = start && (state == IDLE || state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, RUN: begin
        if (start) begin
          next_state = (cnt_start == '0) ? CLEAR : LOAD;
        end
      end
      LOAD: begin
        if (in_valid && wr_ptr_inc == cnt) begin
          next_state = (wr_ptr_inc == DEPTH_W) ? RUN : CLEAR;
        end
      end
      CLEAR: begin
        if (wr_ptr == LAST_W) begin
          next_state = RUN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = wr_ptr[ADDR_W-1:0];
    mem_wdata  = '0;
    core_instr = '0;
    busy       = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready  = 1'b1;
        mem_we    = in_valid;
        mem_wdata = in_data;
        busy      = 1'b1;
      end
      CLEAR: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      RUN: begin
        mem_addr   = core_pc[ADDR_W+1:2];
        core_instr = mem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      if (accept_start) begin
        cnt    <= cnt_start;
        wr_ptr <= '0;
      end else if (mem_we) begin
        wr_ptr <= wr_ptr_inc;
      end
      if (busy && start) begin
        err <= 1'b1;
      end
      core_rst_n <= (next_state == RUN);
      done       <= (next_state == RUN) && (state != RUN);
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - directed self-checking bench for imem_load_ctrl
module tb_imem_load_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] core_pc;
  logic [31:0] core_instr;
  logic        core_rst_n;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;

  imem_load_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .core_pc    (core_pc),
    .core_instr (core_instr),
    .core_rst_n (core_rst_n),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  logic [31:0] ram [64];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  wc;
    int          gap;
    int          seed;
    logic [31:0] pc;
    int          inj;
    int          lat;
    int          nd;
    int          nz;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs [6];

  int lat, nd, nz, addr_bad, rst_bad;

  function automatic logic [31:0] gen_word(int seed, int i);
    logic [31:0] s;
    logic [31:0] ii;
    s  = seed;
    ii = i;
    if (seed == 0) begin
      case (i)
        0: return 32'h0050_0113;
        1: return 32'h00C0_0193;
        2: return 32'hFF71_8393;
        default: return 32'hDEAD_0000 | ii;
      endcase
    end
    return {s[7:0], 8'h5A, ii[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Starts a load, streams words with `gap` idle cycles after each accepted word,
  // optionally pulses start again at cycle `inj`, and stops at the done pulse.
  task automatic run_load(input logic [6:0] wc, input int gap, input int seed, input int inj);
    int idx;
    int gapcnt;
    int w;
    idx = 0; gapcnt = 0; w = 0;
    lat = 0; nd = 0; nz = 0; addr_bad = 0; rst_bad = 0;
    @(negedge clk);
    start = 1'b1;
    word_count = wc;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 1; k < 400; k++) begin
      in_valid = (gapcnt == 0);
      in_data  = gen_word(seed, idx);
      start    = (k == inj);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy && core_rst_n) rst_bad++;
      if (mem_we) begin
        if (mem_addr !== 6'(w)) addr_bad++;
        if (in_ready) begin
          nd++;
          if (mem_wdata !== gen_word(seed, idx)) addr_bad++;
        end else begin
          nz++;
          if (mem_wdata !== 32'h0) addr_bad++;
        end
        w++;
      end
      if (in_ready && in_valid) begin
        idx++;
        gapcnt = gap;
      end else if (gapcnt > 0) begin
        gapcnt--;
      end
      @(posedge clk);
      #1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_run(input string tag, input int exp_lat, input int exp_nd,
                           input int exp_nz, input logic [31:0] pc, input logic [31:0] exp_instr,
                           input logic exp_err);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data_writes"}, nd, exp_nd);
    check({tag, "_zero_writes"}, nz, exp_nz);
    check({tag, "_addr_data_order"}, addr_bad, 0);
    check({tag, "_core_held_while_busy"}, rst_bad, 0);
    check({tag, "_core_rst_n_run"}, {31'b0, core_rst_n}, 1);
    check({tag, "_busy_run"}, {31'b0, busy}, 0);
    core_pc = pc;
    #1;
    check({tag, "_core_instr"}, core_instr, exp_instr);
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, {31'b0, done}, 0);
  endtask

  initial begin
    vecs[0] = '{wc: 7'd3,   gap: 0, seed: 0, pc: 32'h0000_0008, inj: 0,  lat: 65, nd: 3,  nz: 61, instr: 32'hFF71_8393, err: 1'b0};
    vecs[1] = '{wc: 7'd2,   gap: 5, seed: 1, pc: 32'h0000_0004, inj: 0,  lat: 70, nd: 2,  nz: 62, instr: 32'h015A_0001, err: 1'b0};
    vecs[2] = '{wc: 7'd0,   gap: 0, seed: 2, pc: 32'h0000_0000, inj: 0,  lat: 65, nd: 0,  nz: 64, instr: 32'h0000_0000, err: 1'b0};
    vecs[3] = '{wc: 7'd64,  gap: 0, seed: 3, pc: 32'h0000_00FC, inj: 0,  lat: 65, nd: 64, nz: 0,  instr: 32'h035A_003F, err: 1'b0};
    vecs[4] = '{wc: 7'd100, gap: 0, seed: 4, pc: 32'h0000_0100, inj: 0,  lat: 65, nd: 64, nz: 0,  instr: 32'h045A_0000, err: 1'b0};
    vecs[5] = '{wc: 7'd5,   gap: 1, seed: 5, pc: 32'h0000_0013, inj: 30, lat: 69, nd: 5,  nz: 59, instr: 32'h055A_0004, err: 1'b1};

    rst_n = 1'b0; start = 1'b0; word_count = '0; in_valid = 1'b0;
    in_data = '0; core_pc = 32'h8;
    #12;
    check("reset_core_rst_n", {31'b0, core_rst_n}, 0);
    check("reset_in_ready",   {31'b0, in_ready}, 0);
    check("reset_err",        {31'b0, err}, 0);
    check("reset_mem_we",     {31'b0, mem_we}, 0);
    check("reset_done",       {31'b0, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy",       {31'b0, busy}, 0);
    check("idle_in_ready",   {31'b0, in_ready}, 0);
    check("idle_core_instr", core_instr, 32'h0);
    check("idle_core_rst_n", {31'b0, core_rst_n}, 0);

    foreach (vecs[i]) begin
      run_load(vecs[i].wc, vecs[i].gap, vecs[i].seed, vecs[i].inj);
      check_run($sformatf("vec%0d", i), vecs[i].lat, vecs[i].nd, vecs[i].nz,
                vecs[i].pc, vecs[i].instr, vecs[i].err);
    end

    // Reload from RUN, then async reset while the second word is on the bus.
    @(negedge clk);
    start = 1'b1;
    word_count = 7'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("reload_core_rst_n_drop", {31'b0, core_rst_n}, 0);
    in_valid = 1'b1;
    in_data  = 32'h1111_0000;
    @(posedge clk);
    #1;
    in_data = 32'h1111_0001;
    #1;
    rst_n = 1'b0;
    #1;
    check("areset_busy",       {31'b0, busy}, 0);
    check("areset_core_rst_n", {31'b0, core_rst_n}, 0);
    check("areset_err",        {31'b0, err}, 0);
    check("areset_in_ready",   {31'b0, in_ready}, 0);
    check("areset_mem_we",     {31'b0, mem_we}, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    run_load(7'd64, 0, 6, 0);
    check_run("after_reset", 65, 64, 0, 32'h0000_0050, 32'h065A_0014, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Boot-time loader and port arbiter for the writable instruction memory of the single-cycle RISC-V core. It accepts a program as a stream of 32-bit words over a valid/ready handshake and writes them sequentially from word address 0. It then zero-fills the rest of the memory and releases the core from reset. After release it hands the memory read port to the core's fetch path (PC to instruction) until a new load is started.

## Interface
- N_Bits, 32: instruction/data width
- DEPTH, 64: instruction memory depth in words
- ADDR_W, $clog2(DEPTH): word-address width
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a load session
- word_count  in  ADDR_W+1  number of words to load; sampled with start
- in_valid  in  1  loader word valid
- in_data  in  N_Bits  loader word
- in_ready  out  1  block accepts in_data this cycle
- core_pc  in  N_Bits  core fetch byte address
- core_instr  out  N_Bits  instruction to core
- core_rst_n  out  1  active-low reset to core, registered
- mem_we  out  1  instruction RAM write enable; write occurs on the clk rising edge
- mem_addr  out  ADDR_W  instruction RAM word address
- mem_wdata  out  N_Bits  instruction RAM write data
- mem_rdata  in  N_Bits  instruction RAM read data, combinational from mem_addr
- busy  out  1  high in LOAD or CLEAR
- done  out  1  one-cycle pulse on entry to RUN
- err  out  1  sticky; start received while busy

## Operation
- States: IDLE, LOAD, CLEAR, RUN. Reset enters IDLE.
- Reset values: state IDLE, wr_ptr 0, core_rst_n 0, done 0, err 0.
- IDLE: in_ready 0, mem_we 0, core_instr 0. On start, go to LOAD.
- Count latch: on start, latch cnt = min(word_count, DEPTH) and clear wr_ptr.
  - If cnt = 0, go directly to CLEAR.
- LOAD: in_ready = 1.
  - Each in_valid & in_ready cycle: mem_we 1, mem_addr = wr_ptr, mem_wdata = in_data; wr_ptr increments.
  - Cycles without in_valid: mem_we 0 and no progress. Stalls are unbounded.
  - After the cnt-th accepted word: go to RUN if wr_ptr reaches DEPTH, otherwise to CLEAR.
- CLEAR: in_ready 0, mem_we 1, mem_wdata 0, mem_addr = wr_ptr; wr_ptr increments every cycle. After writing address DEPTH-1, go to RUN.
- RUN:
  - mem_we 0, mem_addr = core_pc[ADDR_W+1:2], core_instr = mem_rdata.
  - core_pc[1:0] and the bits above ADDR_W+1 are ignored, so addresses wrap modulo DEPTH.
  - On start, go to LOAD (reload).
- core_rst_n is registered as (next_state == RUN). It is 1 in every RUN cycle and drops to 0 in the first cycle of LOAD on reload.
- Outside RUN: mem_addr is driven by wr_ptr and core_instr = 0.
- start in LOAD or CLEAR is ignored and sets err. err clears only on rst_n.
- in_valid outside LOAD is ignored, with in_ready 0.
- Reset mid-load asynchronously returns to IDLE. Partially written memory contents are not restored.

## Timing
- start sampled at edge t; LOAD is active from cycle t+1.
- With in_valid held high, loading N words takes N LOAD cycles followed by DEPTH−N CLEAR cycles.
- RUN (done = 1, core_rst_n = 1) begins in cycle t+1+DEPTH.
- A word is accepted in the same cycle it is presented. There is no skid buffer and in_ready does not depend on in_valid.
- RUN read path is fully combinational from core_pc to core_instr, giving zero added latency for the single-cycle core.

## Structure
- Package imem_load_ctrl_pkg:
  - state enum (IDLE, LOAD, CLEAR, RUN)
  - default DEPTH and N_Bits constants
  - NOP encoding 32'h00000013, reserved for a future hold-instruction option
- Single module with no sub-modules. The instruction RAM stays a separate block that consumes mem_we/mem_addr/mem_wdata.

## Test plan
- Reset then idle: rst_n low → core_rst_n 0, in_ready 0, err 0, mem_we 0. Release reset with no start → state stays IDLE and core_instr stays 0.
- Short load: start with word_count=3; words 0x00500113, 0x00C00193, 0xFF718393 sent back-to-back.
  - Expect writes to addresses 0–2, then 61 zero writes to addresses 3–63.
  - done pulses at cycle t+65. With core_pc=8, core_instr = 0xFF718393.
- Stalled loader: word_count=2 with in_valid gaps of 5 cycles → exactly 2 data writes and wr_ptr frozen during gaps; RUN is entered only after CLEAR completes.
- Boundary counts:
  - word_count=0 → 64 CLEAR cycles, then RUN.
  - word_count=64 → no CLEAR cycles.
  - word_count=100 → clamped to 64.
  - core_pc=0x100 reads address 0.
- Protocol errors: start asserted during CLEAR → ignored and err=1. Reload start during RUN → core_rst_n drops the next cycle and the new program replaces the old one.
- Async reset at the 2nd word of LOAD → immediate IDLE, core_rst_n 0, err 0. A subsequent full load succeeds.
